// File: rtl/rc4_decrypt_seq.sv
// RC4 sequencer: S-box init, key scheduling, then optional PRGA decryption of a message ROM into a result RAM.
// Build macro ASCII_CHECK_EN: abort decryption on the first byte that is not a-z or space.
module rc4_decrypt_seq #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32,
    parameter int MSG_AW    = 5,
    parameter int RD_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [KEY_BYTES*8-1:0] key,
    output logic                   busy,
    output logic                   done,
    input  logic                   done_ack,
    output logic                   fail,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wdata,
    input  logic [7:0]             s_rdata,
    output logic                   s_wren,
    output logic [MSG_AW-1:0]      rom_addr,
    input  logic [7:0]             rom_rdata,
    output logic [MSG_AW-1:0]      ram_addr,
    output logic [7:0]             ram_wdata,
    output logic                   ram_wren
);

    localparam int              KW     = KEY_BYTES * 8;
    localparam logic [MSG_AW:0] K_LAST = (MSG_AW + 1)'(MSG_LEN - 1);
    localparam logic            W_LAST = 1'(RD_LAT - 1);

    typedef enum logic [3:0] {
        IDLE, INIT,
        KSA_RI, KSA_RJ, KSA_WRI, KSA_WRJ,
        PRGA_RI, PRGA_RJ, PRGA_WRI, PRGA_WRJ, PRGA_RF, PRGA_CAP, PRGA_WR,
        RD_WAIT, COMPLETE
    } state_t;

    state_t            state_q, state_d, ret_q, ret_d;
    logic              wcnt_q, wcnt_d;
    logic [7:0]        i_q, i_d, j_q, j_d;
    logic [MSG_AW:0]   k_q, k_d;
    logic [7:0]        si_q, si_d, sj_q, sj_d, f_q, f_d, ct_q, ct_d;
    logic [KW-1:0]     key_q, key_d;
    logic              mode_q, mode_d;
    logic              busy_q, busy_d, done_q, done_d, fail_q, fail_d;
    logic [7:0]        s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
    logic              s_wren_q, s_wren_d;
    logic [MSG_AW-1:0] rom_addr_q, rom_addr_d, ram_addr_q, ram_addr_d;
    logic [7:0]        ram_wdata_q, ram_wdata_d;
    logic              ram_wren_q, ram_wren_d;

    logic [7:0] kbyte, j_ksa, j_prga, i_inc, pt;
    logic       pt_ok;

    always_comb begin
        kbyte  = key_q[KW-1 -: 8];
        j_ksa  = j_q + s_rdata + kbyte;
        j_prga = j_q + s_rdata;
        i_inc  = i_q + 8'd1;
        pt     = f_q ^ ct_q;
        pt_ok  = ((pt >= 8'h61) && (pt <= 8'h7A)) || (pt == 8'h20);

        state_d = state_q;
        ret_d   = ret_q;
        wcnt_d  = wcnt_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        ct_d    = ct_q;
        key_d   = key_q;
        mode_d  = mode_q;
        fail_d  = fail_q;
        // memory-facing outputs idle at zero unless the current state drives them
        s_addr_d    = 8'd0;
        s_wdata_d   = 8'd0;
        s_wren_d    = 1'b0;
        rom_addr_d  = '0;
        ram_addr_d  = '0;
        ram_wdata_d = 8'd0;
        ram_wren_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
                    mode_d  = mode;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    state_d = INIT;
                end
            end
            INIT: begin
                s_addr_d  = i_q;
                s_wdata_d = i_q;
                s_wren_d  = 1'b1;
                i_d       = i_inc;
                if (i_q == 8'hFF) begin
                    j_d     = 8'd0;
                    state_d = KSA_RI;
                end
            end
            KSA_RI: begin
                s_addr_d = i_q;
                wcnt_d   = 1'b0;
                ret_d    = KSA_RJ;
                state_d  = RD_WAIT;
            end
            KSA_RJ: begin
                si_d     = s_rdata;
                j_d      = j_ksa;
                s_addr_d = j_ksa;
                wcnt_d   = 1'b0;
                ret_d    = KSA_WRI;
                state_d  = RD_WAIT;
            end
            KSA_WRI: begin
                s_addr_d  = i_q;
                s_wdata_d = s_rdata;
                s_wren_d  = 1'b1;
                state_d   = KSA_WRJ;
            end
            KSA_WRJ: begin
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_wren_d  = 1'b1;
                // rotating the key keeps the next key byte at the top, avoiding i mod KEY_BYTES
                key_d     = (key_q << 8) | (key_q >> (KW - 8));
                i_d       = i_inc;
                if (i_q != 8'hFF) begin
                    state_d = KSA_RI;
                end else if (mode_q) begin
                    j_d     = 8'd0;
                    k_d     = '0;
                    state_d = PRGA_RI;
                end else begin
                    state_d = COMPLETE;
                end
            end
            PRGA_RI: begin
                i_d      = i_inc;
                s_addr_d = i_inc;
                wcnt_d   = 1'b0;
                ret_d    = PRGA_RJ;
                state_d  = RD_WAIT;
            end
            PRGA_RJ: begin
                si_d     = s_rdata;
                j_d      = j_prga;
                s_addr_d = j_prga;
                wcnt_d   = 1'b0;
                ret_d    = PRGA_WRI;
                state_d  = RD_WAIT;
            end
            PRGA_WRI: begin
                sj_d      = s_rdata;
                s_addr_d  = i_q;
                s_wdata_d = s_rdata;
                s_wren_d  = 1'b1;
                state_d   = PRGA_WRJ;
            end
            PRGA_WRJ: begin
                s_addr_d  = j_q;
                s_wdata_d = si_q;
                s_wren_d  = 1'b1;
                state_d   = PRGA_RF;
            end
            PRGA_RF: begin
                s_addr_d   = si_q + sj_q;
                rom_addr_d = k_q[MSG_AW-1:0];
                wcnt_d     = 1'b0;
                ret_d      = PRGA_CAP;
                state_d    = RD_WAIT;
            end
            PRGA_CAP: begin
                f_d     = s_rdata;
                ct_d    = rom_rdata;
                state_d = PRGA_WR;
            end
            PRGA_WR: begin
`ifdef ASCII_CHECK_EN
                if (!pt_ok) begin
                    fail_d  = 1'b1;
                    state_d = COMPLETE;
                end else begin
`else
                begin
`endif
                    ram_addr_d  = k_q[MSG_AW-1:0];
                    ram_wdata_d = pt;
                    ram_wren_d  = 1'b1;
                    if (k_q == K_LAST) begin
                        state_d = COMPLETE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = PRGA_RI;
                    end
                end
            end
            RD_WAIT: begin
                if (wcnt_q == W_LAST) state_d = ret_q;
                else wcnt_d = 1'b1;
            end
            COMPLETE: begin
                if (done_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == COMPLETE);
        if (state_d == IDLE) fail_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            wcnt_q      <= 1'b0;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            k_q         <= '0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            f_q         <= 8'd0;
            ct_q        <= 8'd0;
            key_q       <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            s_addr_q    <= 8'd0;
            s_wdata_q   <= 8'd0;
            s_wren_q    <= 1'b0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 8'd0;
            ram_wren_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            wcnt_q      <= wcnt_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            f_q         <= f_d;
            ct_q        <= ct_d;
            key_q       <= key_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wren_q    <= s_wren_d;
            rom_addr_q  <= rom_addr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_wren_q  <= ram_wren_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign s_wren    = s_wren_q;
    assign rom_addr  = rom_addr_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_wren  = ram_wren_q;

endmodule

// File: tb/tb_rc4_decrypt_seq.sv
// Bench for rc4_decrypt_seq: instance 0 uses 1-cycle memories, instance 1 uses 2-cycle memories,
// both checked against an array-based RC4 reference model.
module tb_rc4_decrypt_seq;

    localparam int MSG_LEN = 9;
    localparam int MSG_AW  = 4;
    localparam int TMO     = 20000;

    logic clk = 1'b0;
    logic reset_n;
    logic [1:0] start, mode, done_ack, busy, done, fail, s_wren, ram_wren;
    logic [1:0][23:0] key;
    logic [1:0][7:0] s_addr, s_wdata, s_rdata, rom_rdata, ram_wdata;
    logic [1:0][MSG_AW-1:0] rom_addr, ram_addr;

    logic [7:0] smem [2][256];
    logic [7:0] ram_mem [2][16];
    logic [7:0] rom_mem [16];
    logic [7:0] s_p1 [2], s_p2 [2], r_p1 [2], r_p2 [2];
    int s_wr_cnt [2], ram_wr_cnt [2], both_wr [2];

    logic [7:0] exp_s [256];
    logic [7:0] exp_ram [16];
    int exp_wr;
    bit exp_fail;
    int nvec, nerr;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        rc4_decrypt_seq #(.KEY_BYTES(3), .MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW), .RD_LAT(g + 1)) u_dut (
            .clk(clk), .reset_n(reset_n), .start(start[g]), .mode(mode[g]), .key(key[g]),
            .busy(busy[g]), .done(done[g]), .done_ack(done_ack[g]), .fail(fail[g]),
            .s_addr(s_addr[g]), .s_wdata(s_wdata[g]), .s_rdata(s_rdata[g]), .s_wren(s_wren[g]),
            .rom_addr(rom_addr[g]), .rom_rdata(rom_rdata[g]),
            .ram_addr(ram_addr[g]), .ram_wdata(ram_wdata[g]), .ram_wren(ram_wren[g])
        );
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (s_wren[g]) begin
                smem[g][s_addr[g]] <= s_wdata[g];
                s_wr_cnt[g] <= s_wr_cnt[g] + 1;
            end
            if (ram_wren[g]) begin
                ram_mem[g][ram_addr[g]] <= ram_wdata[g];
                ram_wr_cnt[g] <= ram_wr_cnt[g] + 1;
            end
            if (s_wren[g] && ram_wren[g]) both_wr[g] <= both_wr[g] + 1;
            s_p1[g] <= smem[g][s_addr[g]];
            s_p2[g] <= s_p1[g];
            r_p1[g] <= rom_mem[rom_addr[g]];
            r_p2[g] <= r_p1[g];
        end
    end

    assign s_rdata[0]   = s_p1[0];
    assign s_rdata[1]   = s_p2[1];
    assign rom_rdata[0] = r_p1[0];
    assign rom_rdata[1] = r_p2[1];

    function automatic logic [36:0] outs(input int g);
        return {busy[g], done[g], fail[g], s_addr[g], s_wdata[g], s_wren[g],
                rom_addr[g], ram_addr[g], ram_wdata[g], ram_wren[g]};
    endfunction

    function automatic bit ascii_ok(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
    endfunction

    // Straight-line RC4 on arrays; result RAM starts from the bench memory's current contents.
    task automatic model(input int g, input logic [23:0] k, input bit m);
        logic [7:0] kb [3];
        logic [7:0] t, f, p;
        int ii, jj;
        kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
        for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
        jj = 0;
        for (int i = 0; i < 256; i++) begin
            jj = (jj + int'(exp_s[i]) + int'(kb[i % 3])) % 256;
            t = exp_s[i]; exp_s[i] = exp_s[jj]; exp_s[jj] = t;
        end
        for (int r = 0; r < 16; r++) exp_ram[r] = ram_mem[g][r];
        exp_wr = 0;
        exp_fail = 0;
        if (m) begin
            ii = 0; jj = 0;
            for (int n = 0; n < MSG_LEN; n++) begin
                ii = (ii + 1) % 256;
                jj = (jj + int'(exp_s[ii])) % 256;
                t = exp_s[ii]; exp_s[ii] = exp_s[jj]; exp_s[jj] = t;
                f = exp_s[(int'(exp_s[ii]) + int'(exp_s[jj])) % 256];
                p = f ^ rom_mem[n];
`ifdef ASCII_CHECK_EN
                if (!ascii_ok(p)) begin
                    exp_fail = 1;
                    break;
                end
`endif
                exp_ram[n] = p;
                exp_wr++;
            end
        end
    endtask

    task automatic start_run(input int g, input logic [23:0] k, input bit m);
        @(negedge clk);
        key[g] = k; mode[g] = m; start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
        nvec++;
        if (busy[g] !== 1'b1) begin
            nerr++; $display("FAIL busy_on_start inst%0d: got %b want 1", g, busy[g]);
        end
    endtask

    task automatic wait_done(input int g, input string tag);
        int c = 0;
        while (done[g] !== 1'b1 && c < TMO) begin
            @(negedge clk); c++;
        end
        nvec++;
        if (c >= TMO) begin
            nerr++; $display("FAIL %s timeout inst%0d: done=%b after %0d cycles", tag, g, done[g], c);
        end
        @(negedge clk);
    endtask

    task automatic check_result(input int g, input string tag, input int w0, input int b0);
        int sbad, rbad;
        sbad = 0; rbad = 0;
        for (int i = 0; i < 256; i++) if (smem[g][i] !== exp_s[i]) sbad++;
        for (int i = 0; i < 16; i++) if (ram_mem[g][i] !== exp_ram[i]) rbad++;
        nvec++;
        if (sbad != 0) begin nerr++; $display("FAIL %s sbox inst%0d: %0d bytes differ, want 0", tag, g, sbad); end
        nvec++;
        if (rbad != 0) begin nerr++; $display("FAIL %s ram inst%0d: %0d bytes differ, want 0", tag, g, rbad); end
        nvec++;
        if (fail[g] !== exp_fail) begin nerr++; $display("FAIL %s fail inst%0d: got %b want %b", tag, g, fail[g], exp_fail); end
        nvec++;
        if (ram_wr_cnt[g] - w0 != exp_wr) begin
            nerr++; $display("FAIL %s ram_writes inst%0d: got %0d want %0d", tag, g, ram_wr_cnt[g] - w0, exp_wr);
        end
        nvec++;
        if (both_wr[g] != b0) begin nerr++; $display("FAIL %s dual_wren inst%0d: got %0d want %0d", tag, g, both_wr[g], b0); end
        nvec++;
        if (busy[g] !== 1'b1 || done[g] !== 1'b1) begin
            nerr++; $display("FAIL %s complete inst%0d: busy=%b done=%b want 1 1", tag, g, busy[g], done[g]);
        end
    endtask

    task automatic ack(input int g);
        @(negedge clk);
        done_ack[g] = 1'b1;
        @(negedge clk);
        done_ack[g] = 1'b0;
        nvec++;
        if ({busy[g], done[g], fail[g]} !== 3'b000) begin
            nerr++; $display("FAIL ack inst%0d: busy/done/fail=%b want 000", g, {busy[g], done[g], fail[g]});
        end
    endtask

    task automatic run_to_done(input int g, input logic [23:0] k, input bit m, input string tag);
        int w0, b0;
        model(g, k, m);
        w0 = ram_wr_cnt[g];
        b0 = both_wr[g];
        start_run(g, k, m);
        wait_done(g, tag);
        check_result(g, tag, w0, b0);
    endtask

    task automatic load_kat_rom();
        logic [71:0] ct;
        ct = 72'hBBF316E8D940AF0AD3;
        for (int n = 0; n < MSG_LEN; n++) rom_mem[n] = ct[(8 - n) * 8 +: 8];
    endtask

    task automatic test_reset();
        for (int g = 0; g < 2; g++) begin
            nvec++;
            if (outs(g) !== 37'd0) begin nerr++; $display("FAIL reset_outputs inst%0d: got %h want 0", g, outs(g)); end
        end
    endtask

    task automatic test_reset_mid_ksa();
        start_run(0, 24'($urandom), 1'b1);
        repeat (900) @(negedge clk);
        nvec++;
        if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
            nerr++; $display("FAIL mid_ksa_running: busy=%b done=%b want 1 0", busy[0], done[0]);
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        for (int g = 0; g < 2; g++) begin
            nvec++;
            if (outs(g) !== 37'd0) begin nerr++; $display("FAIL mid_reset_outputs inst%0d: got %h want 0", g, outs(g)); end
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_to_done(0, 24'($urandom), 1'b1, "after_reset");
        ack(0);
    endtask

    task automatic test_mode0_zero_key();
        run_to_done(0, 24'h000000, 1'b0, "mode0_zero");
        ack(0);
    endtask

    task automatic test_kat();
        logic [71:0] ptxt;
        logic [7:0] before0;
        ptxt = "Plaintext";
        load_kat_rom();
        before0 = ram_mem[0][0];
        run_to_done(0, 24'h4B6579, 1'b1, "kat");
`ifdef ASCII_CHECK_EN
        nvec++;
        if (fail[0] !== 1'b1 || ram_mem[0][0] !== before0) begin
            nerr++; $display("FAIL kat_abort: fail=%b ram0=%h want 1 %h", fail[0], ram_mem[0][0], before0);
        end
`else
        for (int n = 0; n < MSG_LEN; n++) begin
            nvec++;
            if (ram_mem[0][n] !== ptxt[(8 - n) * 8 +: 8]) begin
                nerr++; $display("FAIL kat_byte%0d: got %h want %h (prev %h)", n, ram_mem[0][n], ptxt[(8 - n) * 8 +: 8], before0);
            end
        end
`endif
        ack(0);
    endtask

    task automatic test_rdlat2_hold();
        int bad, sw0;
        load_kat_rom();
        run_to_done(1, 24'h4B6579, 1'b1, "kat_lat2");
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (done[1] !== 1'b1 || busy[1] !== 1'b1) bad++;
        end
        nvec++;
        if (bad != 0) begin nerr++; $display("FAIL hold_done: %0d cycles without done, want 0", bad); end
        sw0 = s_wr_cnt[1];
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (5) @(negedge clk);
        nvec++;
        if (done[1] !== 1'b1 || s_wr_cnt[1] != sw0) begin
            nerr++; $display("FAIL start_in_complete: done=%b s_writes=%0d want 1 %0d", done[1], s_wr_cnt[1], sw0);
        end
        ack(1);
    endtask

    task automatic test_handshake();
        int sw0;
        done_ack[0] = 1'b1;
        @(negedge clk);
        done_ack[0] = 1'b0;
        repeat (3) @(negedge clk);
        nvec++;
        if (outs(0) !== 37'd0) begin nerr++; $display("FAIL ack_in_idle: got %h want 0", outs(0)); end
        run_to_done(0, 24'($urandom), 1'b0, "handshake");
        sw0 = s_wr_cnt[0];
        start[0] = 1'b1; done_ack[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; done_ack[0] = 1'b0;
        nvec++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            nerr++; $display("FAIL start_with_ack: busy=%b done=%b want 0 0", busy[0], done[0]);
        end
        repeat (5) @(negedge clk);
        nvec++;
        if (busy[0] !== 1'b0 || s_wr_cnt[0] != sw0) begin
            nerr++; $display("FAIL no_restart: busy=%b s_writes=%0d want 0 %0d", busy[0], s_wr_cnt[0], sw0);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int g;
            bit m;
            g = r % 2;
            m = (r < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int n = 0; n < 16; n++) rom_mem[n] = 8'($urandom);
            run_to_done(g, 24'($urandom), m, "random");
            ack(g);
        end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        reset_n = 1'b0;
        start = '0; mode = '0; done_ack = '0; key = '0;
        for (int n = 0; n < 16; n++) rom_mem[n] = 8'd0;
        repeat (3) @(negedge clk);
        test_reset();
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_reset_mid_ksa();
        test_mode0_zero_key();
        test_kat();
        test_rdlat2_hold();
        test_handshake();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
